// File: rtl/cmp_arb_pkg.sv
// cmp_arb_pkg: shared response type, stats width and round-robin pick helper
// used by cmp_arb and its rr_arb picker.
package cmp_arb_pkg;
    localparam int STAT_W = 16;
    localparam int MAX_N = 16;
    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_rsp_t;
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;
    // Scans downward so the smallest offset from ptr is the last (winning) write.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] vld, input logic [3:0] ptr, input int n);
        rr_pick_t r;
        int k;
        r = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % n;
            if (i < n && vld[k]) begin
                r.found = 1'b1;
                r.idx = 4'(k);
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/cmp_arb_if.sv
// cmp_arb_if: request/response bundle between the clients, cmp_arb and the
// response consumer.
interface cmp_arb_if #(parameter int N = 4, parameter int W = 32);
    logic [N-1:0]         i_req_vld;
    logic [N*W-1:0]       i_req_a;
    logic [N*W-1:0]       i_req_b;
    logic [N-1:0]         o_req_rdy;
    logic                 o_rsp_vld;
    logic [$clog2(N)-1:0] o_rsp_id;
    logic                 o_rsp_eq;
    logic                 o_rsp_gt;
    logic                 o_rsp_lt;
    logic                 i_rsp_rdy;
    modport slave (
        input  i_req_vld, i_req_a, i_req_b, i_rsp_rdy,
        output o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_eq, o_rsp_gt, o_rsp_lt
    );
    modport master (
        output i_req_vld, i_req_a, i_req_b, i_rsp_rdy,
        input  o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_eq, o_rsp_gt, o_rsp_lt
    );
endinterface

// File: rtl/cmp.sv
// cmp: W-bit magnitude comparator; FPGA_INFER selects a subtract-based form
// that maps onto carry chains.
module cmp #(
    parameter int W = 32,
    parameter int IS_SIGNED = 1,
    parameter int FPGA_INFER = 0
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq,
    output logic         o_gt,
    output logic         o_lt
);
    logic [W-1:0] w_a, w_b;
    // Flipping the sign bits turns a signed compare into an unsigned one.
    assign w_a = i_a ^ (W'(IS_SIGNED != 0) << (W - 1));
    assign w_b = i_b ^ (W'(IS_SIGNED != 0) << (W - 1));
    assign o_eq = w_a == w_b;
    generate
        if (FPGA_INFER != 0) begin : g_sub
            logic [W:0] w_d;
            assign w_d = {1'b0, w_a} - {1'b0, w_b};
            assign o_lt = w_d[W];
            assign o_gt = ~w_d[W] & ~o_eq;
        end else begin : g_rel
            assign o_lt = w_a < w_b;
            assign o_gt = w_a > w_b;
        end
    endgenerate
endmodule

// File: rtl/cmp_arb_rr_arb.sv
// rr_arb: N-way round-robin picker; the pointer moves to one past the
// accepted requester and holds otherwise.
module rr_arb import cmp_arb_pkg::*; #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_vld,
    input  logic                 i_en,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_id,
    output logic                 o_accept
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] r_ptr;
    rr_pick_t      w_pick;
    assign w_pick = rr_pick(MAX_N'(i_vld), 4'(r_ptr), N);
    assign o_id = IW'(w_pick.idx);
    assign o_accept = i_en & w_pick.found;
    assign o_gnt = o_accept ? ({{(N-1){1'b0}}, 1'b1} << o_id) : '0;
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (o_accept)
            r_ptr <= (o_id == IW'(N - 1)) ? '0 : o_id + IW'(1);
    end
endmodule

// File: rtl/cmp_arb.sv
// cmp_arb: round-robin sharing of one cmp comparator among N requesters with a
// registered response slot. Define CMP_ARB_STATS_EN to add grant/stall counters.
module cmp_arb import cmp_arb_pkg::*; #(
    parameter int N = 4,
    parameter int W = 32,
    parameter int IS_SIGNED = 1,
    parameter int FPGA_INFER = 0
) (
    input logic clk,
    input logic rst,
    cmp_arb_if.slave bus
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [N*STAT_W-1:0] o_grant_cnt,
    output logic [STAT_W-1:0]   o_stall_cnt
`endif
);
    localparam int IW = $clog2(N);
    logic          w_slot_free, w_accept;
    logic [IW-1:0] w_id, r_id;
    logic [W-1:0]  w_a, w_b;
    logic          w_eq, w_gt, w_lt;
    logic          r_vld;
    cmp_rsp_t      r_rsp;
    assign w_slot_free = ~r_vld | bus.i_rsp_rdy;
    rr_arb #(.N(N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_vld    (bus.i_req_vld),
        .i_en     (w_slot_free & ~rst),
        .o_gnt    (bus.o_req_rdy),
        .o_id     (w_id),
        .o_accept (w_accept)
    );
    assign w_a = bus.i_req_a[w_id*W +: W];
    assign w_b = bus.i_req_b[w_id*W +: W];
    cmp #(.W(W), .IS_SIGNED(IS_SIGNED), .FPGA_INFER(FPGA_INFER)) u_cmp (
        .i_a  (w_a),
        .i_b  (w_b),
        .o_eq (w_eq),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );
    // An accept always wins over a drain so back-to-back responses need no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_id <= '0;
            r_rsp <= '0;
        end else if (w_accept) begin
            r_vld <= 1'b1;
            r_id <= w_id;
            r_rsp <= {w_eq, w_gt, w_lt};
        end else if (bus.i_rsp_rdy) begin
            r_vld <= 1'b0;
        end
    end
    assign bus.o_rsp_vld = r_vld;
    assign bus.o_rsp_id = r_id;
    assign bus.o_rsp_eq = r_rsp.eq;
    assign bus.o_rsp_gt = r_rsp.gt;
    assign bus.o_rsp_lt = r_rsp.lt;
`ifdef CMP_ARB_STATS_EN
    logic [N-1:0][STAT_W-1:0] r_grant_cnt;
    logic [STAT_W-1:0]        r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && r_grant_cnt[w_id] != '1)
                r_grant_cnt[w_id] <= r_grant_cnt[w_id] + STAT_W'(1);
            if (r_vld && !bus.i_rsp_rdy && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end
    assign o_grant_cnt = r_grant_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_cmp_arb.sv
// tb_cmp_arb: directed plus random stimulus against a round-robin model with a
// response scoreboard; a second unsigned instance covers IS_SIGNED=0.
module tb_cmp_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    cmp_arb_if #(.N(4), .W(32)) s ();
    cmp_arb_if #(.N(4), .W(32)) u ();
`ifdef CMP_ARB_STATS_EN
    logic [63:0] s_gcnt, u_gcnt;
    logic [15:0] s_scnt, u_scnt;
`endif
    cmp_arb #(.N(4), .W(32), .IS_SIGNED(1), .FPGA_INFER(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (s)
`ifdef CMP_ARB_STATS_EN
        , .o_grant_cnt (s_gcnt), .o_stall_cnt (s_scnt)
`endif
    );
    cmp_arb #(.N(4), .W(32), .IS_SIGNED(0), .FPGA_INFER(1)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (u)
`ifdef CMP_ARB_STATS_EN
        , .o_grant_cnt (u_gcnt), .o_stall_cnt (u_scnt)
`endif
    );
    logic [31:0] a_op [4];
    logic [31:0] b_op [4];
    logic [4:0]  q [$];
    int          m_ptr = 0;
    int          n_err = 0;
    int          n_chk = 0;
    function automatic logic [2:0] exp_rsp(input logic [31:0] a, input logic [31:0] b, input bit sg);
        if (sg)
            return {a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
        return {a == b, a > b, a < b};
    endfunction
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask
    // One clock of stimulus: predict the grant and the visible response, then commit the model.
    task automatic step(input logic [3:0] vld, input logic rrdy, input logic rs);
        int g;
        logic sf;
        @(negedge clk);
        rst = rs;
        s.i_req_vld = vld;
        s.i_rsp_rdy = rrdy;
        for (int k = 0; k < 4; k++) begin
            s.i_req_a[k*32 +: 32] = a_op[k];
            s.i_req_b[k*32 +: 32] = b_op[k];
        end
        #1;
        sf = (q.size() == 0) || rrdy;
        g = -1;
        if (!rs && sf)
            for (int i = 0; i < 4; i++)
                if (g < 0 && vld[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
        check("req_rdy", 64'(s.o_req_rdy), g < 0 ? 64'd0 : 64'd1 << g);
        if (q.size() > 0) begin
            check("rsp", 64'({s.o_rsp_vld, s.o_rsp_id, s.o_rsp_eq, s.o_rsp_gt, s.o_rsp_lt}), 64'({1'b1, q[0]}));
            if (rrdy) void'(q.pop_front());
        end else begin
            check("rsp_vld", 64'(s.o_rsp_vld), 64'd0);
        end
        if (rs) begin
            q.delete();
            m_ptr = 0;
        end else if (g >= 0) begin
            q.push_back({2'(g), exp_rsp(a_op[g], b_op[g], 1'b1)});
            m_ptr = (g + 1) % 4;
        end
    endtask
    initial begin
        rst = 1'b1;
        s.i_req_vld = '0; s.i_req_a = '0; s.i_req_b = '0; s.i_rsp_rdy = 1'b1;
        u.i_req_vld = '0; u.i_req_a = '0; u.i_req_b = '0; u.i_rsp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin a_op[k] = '0; b_op[k] = '0; end
        step(4'b0000, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b0);
        check("rst_out", 64'({s.o_rsp_id, s.o_rsp_eq, s.o_rsp_gt, s.o_rsp_lt}), 64'd0);
        // single request from req1: 5 vs -3
        a_op[1] = 32'd5; b_op[1] = 32'hFFFF_FFFD;
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("single_gt", 64'({s.o_rsp_id, s.o_rsp_eq, s.o_rsp_gt, s.o_rsp_lt}), 64'({2'd1, 3'b010}));
        // all four requesting, pointer left at 2
        a_op[0] = 32'd10; b_op[0] = 32'd10;
        a_op[1] = 32'd20; b_op[1] = 32'd5;
        a_op[2] = 32'd30; b_op[2] = 32'd50;
        a_op[3] = 32'd40; b_op[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // all four from pointer 0
        step(4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // back-pressure on an eq response from req0
        step(4'b0000, 1'b1, 1'b1);
        a_op[0] = 32'd7; b_op[0] = 32'd7;
        step(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // reset while a response is held and req2 waits
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // signed: all-ones is -1 < 1
        a_op[0] = 32'hFFFF_FFFF; b_op[0] = 32'd1;
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        // unsigned instance: all-ones > 1
        @(negedge clk);
        u.i_req_a[31:0] = 32'hFFFF_FFFF; u.i_req_b[31:0] = 32'd1; u.i_req_vld = 4'b0001;
        #1 check("u_rdy", 64'(u.o_req_rdy), 64'd1);
        @(negedge clk);
        u.i_req_vld = 4'b0000;
        #1 check("u_rsp", 64'({u.o_rsp_vld, u.o_rsp_id, u.o_rsp_eq, u.o_rsp_gt, u.o_rsp_lt}),
                 64'({1'b1, 2'd0, exp_rsp(32'hFFFF_FFFF, 32'd1, 1'b0)}));
        // random traffic with random back-pressure
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) begin
                a_op[k] = $urandom() & 32'h8000_0003;
                b_op[k] = $urandom() & 32'h8000_0003;
            end
            step(4'($urandom()), $urandom_range(0, 3) != 0, 1'b0);
        end
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cmp_arb.md
Name: cmp_arb

Overview:
- Round-robin arbiter and sequencer sharing one `cmp` magnitude comparator among N requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle, compares via `cmp`, and returns eq/gt/lt tagged with the requester id through a registered, back-pressurable response port.
- Sits between multiple issue/branch-resolution clients and a single comparator, saving area.

Parameters:
- N, 4, number of requesters (2..16)
- W, 32, operand width
- IS_SIGNED, 1, signed (1) or unsigned (0) comparison, passed to `cmp`
- FPGA_INFER, 0, passed to `cmp`

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_vld  in  N  per-requester request valid
- i_req_a  in  N*W  operand A, requester k at bits [k*W +: W]
- i_req_b  in  N*W  operand B, same packing
- o_req_rdy  out  N  one-hot accept; request k accepted when i_req_vld[k] & o_req_rdy[k]
- o_rsp_vld  out  1  response valid
- o_rsp_id  out  $clog2(N)  id of the requester the response belongs to
- o_rsp_eq  out  1  A == B
- o_rsp_gt  out  1  A > B
- o_rsp_lt  out  1  A < B
- i_rsp_rdy  in  1  response consumer ready

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - o_rsp_vld=0, o_rsp_id=0, eq/gt/lt=0.
  - Round-robin pointer=0.
  - Stats counters=0 (when enabled).
  - Any held response is discarded; no request is accepted during the reset cycle (o_req_rdy=0 while rst=1).
- Output stage: single response register.
  - slot_free = ~o_rsp_vld | i_rsp_rdy, so full throughput of one compare per cycle when the consumer is always ready.
- Arbitration:
  - When slot_free, grant the first asserted i_req_vld[k] searching k = ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - o_req_rdy is one-hot on the granted k, else all 0. o_req_rdy depends combinationally on i_req_vld and i_rsp_rdy.
  - Requesters must not depend on o_req_rdy to assert i_req_vld.
- Pointer update:
  - On accept of k, ptr <= (k+1) mod N, wrapping N-1 -> 0.
  - No accept: ptr holds.
- Datapath:
  - Granted operands are muxed combinationally into one `cmp` instance.
  - Its eq/gt/lt plus the grant id are registered into the response slot on accept.
  - Latency: response valid exactly 1 cycle after the accept cycle.
- Hold:
  - While o_rsp_vld & ~i_rsp_rdy, all response outputs are stable and o_req_rdy=0.
  - Held data is never overwritten.
- Drain without refill: if o_rsp_vld & i_rsp_rdy and no request is valid, o_rsp_vld <= 0.
- Simultaneous drain and accept: the new result replaces the old in the same cycle, with no bubble.
- Exactly one of eq/gt/lt is 1 whenever o_rsp_vld=1. Outputs are don't-care when o_rsp_vld=0, but are held at their last value.
- Request-side rules:
  - Requester k must hold valid and operands stable until accepted.
  - Deasserting before accept is permitted and simply forfeits the slot.

Optional Feature:
- Macro: CMP_ARB_STATS_EN.
- Defined:
  - Adds output o_grant_cnt (N*16 bits): per-requester 16-bit saturating accept counters, which stick at 16'hFFFF.
  - Adds output o_stall_cnt (16 bits): saturating count of cycles with o_rsp_vld & ~i_rsp_rdy.
  - All counters cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `cmp_arb_pkg`:
  - typedef cmp_rsp_t {eq, gt, lt}
  - function rr_pick(vld, ptr) returning grant index + found flag
  - localparam STAT_W = 16
- Sub-modules:
  - Reuse existing `cmp`.
  - One natural new sub-module: `rr_arb` (N-way round-robin picker with pointer register), reusable by other shared-resource blocks.

Test Plan:
- Single request, N=4, W=32 signed: req1 A=5, B=-3, i_rsp_rdy=1 -> o_req_rdy=4'b0010; next cycle o_rsp_vld=1, id=1, gt=1; ptr=2.
- All four requesting continuously, consumer ready, ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; one response per cycle; ids in that order.
- Back-pressure: response for req0 (A=B=7, eq=1) held with i_rsp_rdy=0 for 3 cycles -> outputs stable, o_req_rdy=0; on release, the next grant goes to req1 in the same cycle.
- Unsigned (IS_SIGNED=0): A=32'hFFFF_FFFF, B=1 -> gt=1; signed build, same operands -> lt=1.
- Reset mid-operation: o_rsp_vld=1 held, rst pulsed 1 cycle -> o_rsp_vld=0, ptr=0; the pending req2 is granted only after rst deasserts.
- With CMP_ARB_STATS_EN: 70000 grants to req0 -> o_grant_cnt[0]=16'hFFFF; 5 stall cycles -> o_stall_cnt=5.
